// File: rtl/aznable_pkg.sv
// Shared constants for the aznable keyboard FIFO window.
package aznable_pkg;

  // Register select values on cpu_addr[1:0]
  localparam logic [1:0] KEYFIFO_REG_STATUS = 2'd0;
  localparam logic [1:0] KEYFIFO_REG_CODE   = 2'd1;
  localparam logic [1:0] KEYFIFO_REG_FLAGS  = 2'd2;

  // One FIFO entry is {pressed, extended, scancode[7:0]}
  localparam int KEYFIFO_ENTRY_W = 10;

  // Upper address byte (cpu_addr[15:8]) decoded outside this block
  localparam logic [7:0] KEYFIFO_BASE = 8'h78;

  // STATUS byte assembly: {empty, overflow, count[5:0]}
  function automatic logic [7:0] keyfifo_status(input logic empty,
                                                input logic overflow,
                                                input logic [6:0] count);
    return {empty, overflow, count[5:0]};
  endfunction

endpackage

// File: rtl/keyfifo_mem.sv
// Key event storage: 2**DEPTH_LOG2 x KEYFIFO_ENTRY_W register array,
// synchronous write, asynchronous read.
module keyfifo_mem
  import aznable_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                       clk_sys,
  input  logic                       we,
  input  logic [DEPTH_LOG2-1:0]      waddr,
  input  logic [KEYFIFO_ENTRY_W-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0]      raddr,
  output logic [KEYFIFO_ENTRY_W-1:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [KEYFIFO_ENTRY_W-1:0] mem_q [DEPTH];

  // Storage carries no reset; the pointers define which slots are valid
  always_ff @(posedge clk_sys) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Head entry is visible without a read cycle
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ps2_key_fifo.sv
// ps2_key event FIFO with a three-register CPU read window.
// Optional feature macro: PS2_KEY_REPEAT_FILTER_EN (drops typematic repeats).
module ps2_key_fifo
  import aznable_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        cs,
  input  logic [1:0]  cpu_addr,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  data_out,
  output logic        irq_pending
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic                       toggle_q, toggle_d;
  logic                       rd_n_q, rd_n_d;

  logic                       key_event;
  logic                       accept_event;
  logic                       pop_req;
  logic                       clear_req;
  logic                       do_pop;
  logic                       do_push;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic [KEYFIFO_ENTRY_W-1:0] head;
  logic [6:0]                 count_ext;

  // Write data is irrelevant: any STATUS write means "clear"
  logic                       unused_cpu_dout;
  assign unused_cpu_dout = ^cpu_dout;

  // Event detection and CPU strobe decode
  always_comb begin
    key_event = ps2_key[10] != toggle_q;
    pop_req   = ~rd_n_q & cpu_rd_n & cs & (cpu_addr == KEYFIFO_REG_CODE);
    clear_req = ~cpu_wr_n & cs & (cpu_addr == KEYFIFO_REG_STATUS);
  end

`ifdef PS2_KEY_REPEAT_FILTER_EN
  logic [8:0] last_down_q, last_down_d;
  logic       last_valid_q, last_valid_d;
  logic       last_match;

  // Typematic filter: a press that repeats the held key is not queued
  always_comb begin
    last_down_d  = last_down_q;
    last_valid_d = last_valid_q;
    last_match   = last_valid_q & (last_down_q == ps2_key[8:0]);
    accept_event = key_event;
    if (key_event) begin
      if (ps2_key[9]) begin
        if (last_match) begin
          accept_event = 1'b0;
        end else begin
          last_down_d  = ps2_key[8:0];
          last_valid_d = 1'b1;
        end
      end else if (last_match) begin
        last_valid_d = 1'b0;
      end
    end
    if (clear_req) begin
      last_down_d  = '0;
      last_valid_d = 1'b0;
    end
  end

  // Held-key tracking registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      last_down_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_down_q  <= last_down_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  // Every event goes to the FIFO
  always_comb begin
    accept_event = key_event;
  end
`endif

  // Pointer, count and overflow next-state; clear beats push and pop,
  // and a pop frees the slot for a push on the same edge when full
  always_comb begin
    fifo_empty = count_q == '0;
    fifo_full  = count_q == CW'(DEPTH);
    do_pop     = pop_req & ~fifo_empty & ~clear_req;
    do_push    = accept_event & ~clear_req & (~fifo_full | do_pop);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    toggle_d   = ps2_key[10];
    rd_n_d     = cpu_rd_n;

    if (clear_req) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
      if (accept_event && !do_push) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      toggle_q   <= 1'b0;
      rd_n_q     <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      toggle_q   <= toggle_d;
      rd_n_q     <= rd_n_d;
    end
  end

  keyfifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk_sys(clk_sys),
    .we     (do_push),
    .waddr  (wr_ptr_q),
    .wdata  (ps2_key[KEYFIFO_ENTRY_W-1:0]),
    .raddr  (rd_ptr_q),
    .rdata  (head)
  );

  // CPU read mux; the bus is driven to zero while the window is deselected
  // so the shared data mux upstream sees a quiet source
  always_comb begin
    count_ext = 7'(count_q);
    data_out  = 8'h00;
    if (cs) begin
      case (cpu_addr)
        KEYFIFO_REG_STATUS: data_out = keyfifo_status(fifo_empty, overflow_q, count_ext);
        KEYFIFO_REG_CODE:   data_out = fifo_empty ? 8'h00 : head[7:0];
        KEYFIFO_REG_FLAGS:  data_out = fifo_empty ? 8'h00 : {6'b0, head[9], head[8]};
        default:            data_out = 8'h00;
      endcase
    end
  end

  assign irq_pending = ~fifo_empty;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Randomized + directed bench for ps2_key_fifo against a queue-based model.
module tb_ps2_key_fifo;

  localparam int DEPTH = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic        cs = 1'b0;
  logic [1:0]  cpu_addr = 2'd0;
  logic        cpu_rd_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  data_out;
  logic        irq_pending;

  int total = 0;
  int bad   = 0;

  ps2_key_fifo #(.DEPTH_LOG2(4)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .cs         (cs),
    .cpu_addr   (cpu_addr),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_dout   (cpu_dout),
    .data_out   (data_out),
    .irq_pending(irq_pending)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------- behavioural model ----------------
  logic [9:0] mq[$];
  bit         movf, mtog, mrdn, mvalid;
  bit [8:0]   mlast;
  bit         m_ev, m_pop, m_clr, m_acc;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      movf = 0; mtog = 0; mrdn = 1; mvalid = 0; mlast = '0;
    end else begin
      m_ev  = ps2_key[10] != mtog;
      m_pop = !mrdn && cpu_rd_n && cs && cpu_addr == 2'd1;
      m_clr = !cpu_wr_n && cs && cpu_addr == 2'd0;
      m_acc = m_ev;
`ifdef PS2_KEY_REPEAT_FILTER_EN
      if (m_ev) begin
        if (ps2_key[9]) begin
          if (mvalid && mlast == ps2_key[8:0]) m_acc = 0;
          else begin mlast = ps2_key[8:0]; mvalid = 1; end
        end else if (mvalid && mlast == ps2_key[8:0]) begin
          mvalid = 0;
        end
      end
`endif
      if (m_clr) begin
        mq.delete(); movf = 0; mvalid = 0; mlast = '0;
      end else begin
        if (m_pop && mq.size() > 0) void'(mq.pop_front());
        if (m_acc) begin
          if (mq.size() < DEPTH) mq.push_back(ps2_key[9:0]);
          else movf = 1;
        end
      end
      mtog = ps2_key[10];
      mrdn = cpu_rd_n;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] exp_do;
  bit         chk_do;
  always @(negedge clk_sys) begin
    chk_do = 1;
    exp_do = 8'h00;
    if (cs) begin
      case (cpu_addr)
        2'd0: exp_do = {mq.size() == 0, movf, 6'(mq.size())};
        2'd1: exp_do = (mq.size() == 0) ? 8'h00 : mq[0][7:0];
        2'd2: begin
          if (mq.size() == 0) chk_do = 0;
          else exp_do = {6'b0, mq[0][9:8]};
        end
        default: exp_do = 8'h00;
      endcase
    end
    total++;
    if (irq_pending !== (mq.size() != 0)) begin
      bad++;
      $display("FAIL cyc_irq t=%0t got %b want %b", $time, irq_pending, mq.size() != 0);
    end
    if (chk_do) begin
      total++;
      if (data_out !== exp_do) begin
        bad++;
        $display("FAIL cyc_data t=%0t addr=%0d got %h want %h", $time, cpu_addr, data_out, exp_do);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk_sys); #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [7:0] v);
    cs = 1; cpu_addr = a; #1; v = data_out; cs = 0; cpu_addr = 2'd0;
  endtask

  task automatic send(input logic [9:0] e);
    ps2_key = {~ps2_key[10], e}; step();
  endtask

  task automatic do_clear();
    cs = 1; cpu_addr = 2'd0; cpu_wr_n = 0; step(); cpu_wr_n = 1; cs = 0;
  endtask

  task automatic do_pop();
    cs = 1; cpu_addr = 2'd1; cpu_rd_n = 0; step(); cpu_rd_n = 1; step(); cs = 0; cpu_addr = 2'd0;
  endtask

  logic [7:0] v;

  initial begin
    // reset
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_irq", {7'b0, irq_pending}, 8'h00);
    reset_n = 1; step();
    rd_reg(2'd0, v); chk("rst_status", v, 8'h80);

    // 1: single event
    ps2_key = {1'b1, 10'h21C}; step();
    rd_reg(2'd0, v); chk("t1_status", v, 8'h01);
    rd_reg(2'd1, v); chk("t1_code", v, 8'h1C);
    rd_reg(2'd2, v); chk("t1_flags", v, 8'h02);
    chk("t1_irq", {7'b0, irq_pending}, 8'h01);

    // 2: 17 events, overflow
    do_clear();
    for (int i = 0; i < 17; i++) send({2'b10, 8'(8'h40 + i)});
    rd_reg(2'd0, v); chk("t2_status", v, 8'h50);
    rd_reg(2'd1, v); chk("t2_code_first", v, 8'h40);
    for (int i = 0; i < 15; i++) do_pop();
    rd_reg(2'd1, v); chk("t2_code_last", v, 8'h4F);
    do_pop();
    rd_reg(2'd0, v); chk("t2_status_empty", v, 8'hC0);

    // 3: long read pops once
    do_clear();
    send(10'h12B);
    cs = 1; cpu_addr = 2'd1; cpu_rd_n = 0;
    repeat (5) step();
    cpu_rd_n = 1; step(); cs = 0;
    rd_reg(2'd0, v); chk("t3_status", v, 8'h80);
    rd_reg(2'd1, v); chk("t3_code", v, 8'h00);

    // 4: full, pop and push on the same edge
    do_clear();
    for (int i = 0; i < 16; i++) send({2'b10, 8'(8'h30 + i)});
    cs = 1; cpu_addr = 2'd1; cpu_rd_n = 0; step();
    cpu_rd_n = 1; ps2_key = {~ps2_key[10], 10'h2AA}; step(); cs = 0;
    rd_reg(2'd0, v); chk("t4_status", v, 8'h10);
    rd_reg(2'd1, v); chk("t4_code", v, 8'h31);
    for (int i = 0; i < 15; i++) do_pop();
    rd_reg(2'd1, v); chk("t4_tail_code", v, 8'hAA);
    rd_reg(2'd2, v); chk("t4_tail_flags", v, 8'h02);

    // 5: clear with a coincident event
    send(10'h155);
    cs = 1; cpu_addr = 2'd0; cpu_wr_n = 0; ps2_key = {~ps2_key[10], 10'h177}; step();
    cpu_wr_n = 1; cs = 0;
    rd_reg(2'd0, v); chk("t5_status_clr", v, 8'h80);
    send(10'h366);
    rd_reg(2'd0, v); chk("t5_status_next", v, 8'h01);
    rd_reg(2'd2, v); chk("t5_flags", v, 8'h03);

    // 6: typematic sequence
    do_clear();
    send(10'h21C); send(10'h21C); send(10'h01C); send(10'h21C);
    rd_reg(2'd0, v);
`ifdef PS2_KEY_REPEAT_FILTER_EN
    chk("t6_count_filter", v, 8'h03);
`else
    chk("t6_count_nofilter", v, 8'h04);
`endif

    // reset in the middle of a CODE read
    cs = 1; cpu_addr = 2'd1; cpu_rd_n = 0; ps2_key = {1'b1, 10'h11C}; step();
    reset_n = 0; #1;
    chk("mid_rst_irq", {7'b0, irq_pending}, 8'h00);
    step(); reset_n = 1;
    cpu_rd_n = 1; step(); cs = 0;
    rd_reg(2'd0, v); chk("mid_rst_status", v, 8'h01);
    rd_reg(2'd1, v); chk("mid_rst_code", v, 8'h1C);

    // randomized traffic, checked every cycle by the compare process
    for (int ph = 0; ph < 6; ph++) begin
      int pop_pct;
      pop_pct = (ph % 2 == 0) ? 5 : 40;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          logic [7:0] code;
          code = ($urandom_range(0, 1) == 0) ? 8'(8'h1C + $urandom_range(0, 1)) : 8'($urandom);
          ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom_range(0, 3) != 0), code};
        end
        cpu_addr = 2'($urandom);
        cs       = $urandom_range(0, 3) != 0;
        cpu_dout = 8'($urandom);
        cpu_wr_n = $urandom_range(0, 59) != 0;
        if ($urandom_range(0, 99) < pop_pct) cpu_rd_n = ~cpu_rd_n;
        else if (!cpu_rd_n && $urandom_range(0, 1) == 0) cpu_rd_n = 1;
        step();
      end
    end
    cs = 0; cpu_rd_n = 1; cpu_wr_n = 1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
